// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, square size and sprite-motion FSM encoding.
package vga_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned SQ_SIZE_DEF  = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_CALC   = 2'd2,
    ST_COMMIT = 2'd3
  } motion_state_e;

endpackage

// File: rtl/sprite_motion_ctrl_axis_step.sv
// Single-axis saturating step: moves a coordinate by STEP toward 0 or toward limit.
module axis_step #(
  parameter int unsigned W    = 10,
  parameter int unsigned STEP = 1
) (
  input  logic [W-1:0] coord,
  input  logic         inc,
  input  logic         dec,
  input  logic [W-1:0] limit,
  output logic [W-1:0] next
);

  logic [10:0] wide;
  logic [10:0] sum;

  always_comb begin
    wide = 11'(coord);
    sum  = wide + 11'(STEP);
    next = coord;
    // Opposing requests cancel; 11-bit math keeps the sum from wrapping.
    if (inc && !dec) begin
      next = (sum >= 11'(limit)) ? limit : W'(sum);
    end else if (dec && !inc) begin
      next = (wide < 11'(STEP)) ? '0 : W'(wide - 11'(STEP));
    end
  end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Moves the VGA square once every FRAMES_PER_STEP frames from synchronized
// direction requests; position only changes just after the vsync edge.
module sprite_motion_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned SQ_SIZE         = SQ_SIZE_DEF,
  parameter int unsigned H_ACTIVE        = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE        = V_ACTIVE_DEF,
  parameter int unsigned STEP            = 1,
  parameter int unsigned FRAMES_PER_STEP = 1,
  parameter int unsigned INIT_X          = 320,
  parameter int unsigned INIT_Y          = 240
) (
  input  logic       iVGA_CLK,
  input  logic       iRST_n,
  input  logic       iVS,
  input  logic       move_up,
  input  logic       move_down,
  input  logic       move_left,
  input  logic       move_right,
  output logic [9:0] oSQ_X,
  output logic [8:0] oSQ_Y,
  output logic       oSTEP,
  output logic [3:0] oAT_EDGE
);

  localparam logic [9:0] X_MAX   = 10'(H_ACTIVE - SQ_SIZE);
  localparam logic [8:0] Y_MAX   = 9'(V_ACTIVE - SQ_SIZE);
  localparam logic [5:0] FC_LAST = 6'(FRAMES_PER_STEP - 1);

  // Direction vectors are {up, down, left, right}.
  logic [3:0]    sync1_q, sync1_d;
  logic [3:0]    sync2_q, sync2_d;
  logic [3:0]    dir_q, dir_d;
  logic          vs_q, vs_d;
  logic          vs_prev_q, vs_prev_d;
  logic [5:0]    fcnt_q, fcnt_d;
  motion_state_e state_q, state_d;
  logic [9:0]    x_q, x_d, x_step;
  logic [8:0]    y_q, y_d, y_step;
  logic          tick;
  logic          trigger;

  axis_step #(.W(10), .STEP(STEP)) u_x_step (
    .coord (x_q),
    .inc   (dir_q[0]),
    .dec   (dir_q[1]),
    .limit (X_MAX),
    .next  (x_step)
  );

  axis_step #(.W(9), .STEP(STEP)) u_y_step (
    .coord (y_q),
    .inc   (dir_q[2]),
    .dec   (dir_q[3]),
    .limit (Y_MAX),
    .next  (y_step)
  );

  always_comb begin
    sync1_d   = {move_up, move_down, move_left, move_right};
    sync2_d   = sync1_q;
    vs_d      = iVS;
    vs_prev_d = vs_q;
    tick      = vs_prev_q & ~vs_q;
    trigger   = tick && (fcnt_q == FC_LAST);

    fcnt_d = fcnt_q;
    if (tick) begin
      fcnt_d = (fcnt_q == FC_LAST) ? '0 : fcnt_q + 6'd1;
    end

    state_d = state_q;
    dir_d   = dir_q;
    x_d     = x_q;
    y_d     = y_q;
    // Ticks outside IDLE only advance the frame counter.
    unique case (state_q)
      ST_IDLE:   if (trigger) state_d = ST_SAMPLE;
      ST_SAMPLE: begin
        dir_d   = sync2_q;
        state_d = ST_CALC;
      end
      ST_CALC: begin
        x_d     = x_step;
        y_d     = y_step;
        state_d = ST_COMMIT;
      end
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      dir_q     <= '0;
      vs_q      <= 1'b0;
      vs_prev_q <= 1'b0;
      fcnt_q    <= '0;
      state_q   <= ST_IDLE;
      x_q       <= 10'(INIT_X);
      y_q       <= 9'(INIT_Y);
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      dir_q     <= dir_d;
      vs_q      <= vs_d;
      vs_prev_q <= vs_prev_d;
      fcnt_q    <= fcnt_d;
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
    end
  end

  assign oSQ_X    = x_q;
  assign oSQ_Y    = y_q;
  assign oSTEP    = (state_q == ST_COMMIT);
  assign oAT_EDGE = {(y_q == 9'd0), (y_q == Y_MAX), (x_q == 10'd0), (x_q == X_MAX)};

endmodule
